linear_accum_crelu: RTL

- Downstream consumer of the int8 matmul stage.
- Accumulates P-lane signed 16-bit partial sums over TILES input tiles (one tile = N inputs) into a per-lane bias-initialised accumulator.
- Requantises each lane by arithmetic right shift, then applies NNUE clipped ReLU (clamp 0..127).
- Emits one int8 activation vector per TILES accepted tiles, through a valid/ready handshake. The vector feeds the next layer's x input.

---
 rtl/nnue_pkg.sv | 11 +
 rtl/crelu_requant.sv | 24 ++
 rtl/linear_accum_crelu.sv | 91 +++++++++
 3 files changed

// File: rtl/nnue_pkg.sv
// Shared widths, clamp limit and FSM state encoding for the NNUE datapath stages.
package nnue_pkg;
  localparam int PSUM_W    = 16;
  localparam int ACT_W     = 8;
  localparam int CRELU_MAX = 127;

  typedef enum logic {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } state_t;
endpackage

// File: rtl/crelu_requant.sv
// Single-lane requantiser: arithmetic right shift, then clipped ReLU into 0..127.
module crelu_requant
  import nnue_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int SHIFT = 6
) (
  input  logic [ACC_W-1:0] acc,
  output logic [ACT_W-1:0] act
);
  logic [ACC_W-1:0] shifted;

  assign shifted = ACC_W'($signed(acc) >>> SHIFT);

  // Non-negative values with any bit at or above bit 7 exceed the clamp limit.
  always_comb begin
    if (shifted[ACC_W-1])
      act = '0;
    else if (|shifted[ACC_W-2:ACT_W-1])
      act = ACT_W'(CRELU_MAX);
    else
      act = shifted[ACT_W-1:0];
  end
endmodule

// File: rtl/linear_accum_crelu.sv
// Accumulates TILES partial-sum tiles per lane on top of a bias, then emits a
// clipped-ReLU int8 activation vector through a valid/ready handshake.
module linear_accum_crelu
  import nnue_pkg::*;
#(
  parameter int P     = 16,
  parameter int TILES = 32,
  parameter int ACC_W = 32,
  parameter int SHIFT = 6,
  localparam int TW   = (TILES > 1) ? $clog2(TILES) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [0:P-1][PSUM_W-1:0]   psum,
  input  logic [0:P-1][ACC_W-1:0]    bias,
  output logic [TW-1:0]              tile_idx,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [0:P-1][ACT_W-1:0]    out
);
  typedef logic [0:P-1][PSUM_W-1:0] psum_vec_t;
  typedef logic [0:P-1][ACT_W-1:0]  act_vec_t;

  state_t           state_reg;
  logic [TW-1:0]    tile_idx_reg;
  logic [ACC_W-1:0] acc_reg  [P];
  logic [ACC_W-1:0] acc_next [P];
  act_vec_t         act_next;
  act_vec_t         out_reg;
  psum_vec_t        psum_in;
  logic             accept;
  logic             last_tile;

  assign psum_in   = psum;
  assign accept    = (state_reg == ACCUM) && in_valid && !clr;
  assign last_tile = (tile_idx_reg == TW'(TILES - 1));

  // Tile 0 starts from the bias, so an aborted vector needs no accumulator clear.
  for (genvar gi = 0; gi < P; gi++) begin : g_lane
    logic [ACC_W-1:0] base;
    assign base          = (tile_idx_reg == '0) ? bias[gi] : acc_reg[gi];
    assign acc_next[gi]  = base + ACC_W'($signed(psum_in[gi]));

    crelu_requant #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
    ) u_crelu (
      .acc (acc_next[gi]),
      .act (act_next[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ACCUM;
      tile_idx_reg <= '0;
      out_reg      <= '0;
      for (int i = 0; i < P; i++) acc_reg[i] <= '0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (clr) begin
            tile_idx_reg <= '0;
          end else if (accept) begin
            for (int i = 0; i < P; i++) acc_reg[i] <= acc_next[i];
            if (last_tile) begin
              tile_idx_reg <= '0;
              out_reg      <= act_next;
              state_reg    <= EMIT;
            end else begin
              tile_idx_reg <= tile_idx_reg + TW'(1);
            end
          end
        end
        EMIT: begin
          // clr is deliberately ignored here so a finished vector is never lost.
          if (out_ready) state_reg <= ACCUM;
        end
        default: state_reg <= ACCUM;
      endcase
    end
  end

  assign in_ready  = (state_reg == ACCUM);
  assign out_valid = (state_reg == EMIT);
  assign tile_idx  = tile_idx_reg;
  assign out       = out_reg;
endmodule
